// File: rtl/peripheral_noc_router_output_arbiter_if.sv
// Handshake bundle for the NoC output arbiter.
// in_*: per-input flit streams (slave side); out_*: merged output link.
interface peripheral_noc_router_output_arbiter_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 2
);
  logic [INPUTS*FLIT_WIDTH-1:0] in_flit;
  logic [INPUTS-1:0]            in_last;
  logic [INPUTS-1:0]            in_valid;
  logic [INPUTS-1:0]            in_ready;
  logic [FLIT_WIDTH-1:0]        out_flit;
  logic                         out_last;
  logic                         out_valid;
  logic                         out_ready;

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/peripheral_noc_router_output_arbiter.sv
// NoC router output stage: round-robin worm arbiter with one output register.
// Ports: clk, rst (sync, active-high), bus (slave modport of the _if bundle).
module peripheral_noc_router_output_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 2
) (
  input logic clk,
  input logic rst,
  peripheral_noc_router_output_arbiter_if.slave bus
);
  localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         prio_q, prio_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;

  logic [IW-1:0]         sel;
  logic [IW-1:0]         cand;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  req;
  logic                  slot_free;
  logic                  accept;

  // Selection: locked worms keep their grant; otherwise the first
  // valid input at or after prio (wrapping) wins.
  always_comb begin
    int idx;
    idx       = 0;
    cand      = '0;
    slot_free = !valid_q || bus.out_ready;
    sel       = grant_q;
    req       = (state_q == LOCKED);
    if (state_q == UNLOCKED) begin
      for (int k = 0; k < INPUTS; k++) begin
        idx  = (int'(prio_q) + k) % INPUTS;
        cand = IW'(idx);
        if (!req && bus.in_valid[cand]) begin
          req = 1'b1;
          sel = cand;
        end
      end
    end
    sel_flit  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (sel == IW'(i)) begin
        sel_flit  = bus.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_last  = bus.in_last[i];
        sel_valid = bus.in_valid[i];
      end
    end
    // Locked grant may see ready without valid; that just stalls.
    for (int i = 0; i < INPUTS; i++) begin
      bus.in_ready[i] = req && slot_free && (sel == IW'(i));
    end
    accept = req && slot_free && sel_valid;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    flit_d  = flit_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (accept) begin
      flit_d  = sel_flit;
      last_d  = sel_last;
      valid_d = 1'b1;
      if (state_q == UNLOCKED) begin
        prio_d = (sel == IW'(INPUTS-1)) ? '0 : sel + 1'b1;
        if (!sel_last) begin
          state_d = LOCKED;
          grant_d = sel;
        end
      end else if (sel_last) begin
        state_d = UNLOCKED;
      end
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      grant_q <= '0;
      prio_q  <= '0;
      flit_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      flit_q  <= flit_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_flit  = flit_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_peripheral_noc_router_output_arbiter.sv
// Testbench for peripheral_noc_router_output_arbiter.
// Vector table, hand sequences (reset, 4 inputs) and a random model run.
module tb_peripheral_noc_router_output_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  peripheral_noc_router_output_arbiter_if #(.FLIT_WIDTH(32), .INPUTS(2)) b2();
  peripheral_noc_router_output_arbiter_if #(.FLIT_WIDTH(32), .INPUTS(4)) b4();

  peripheral_noc_router_output_arbiter #(.FLIT_WIDTH(32), .INPUTS(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  peripheral_noc_router_output_arbiter #(.FLIT_WIDTH(32), .INPUTS(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  l;
    logic [31:0] f0;
    logic [31:0] f1;
    logic        ordy;
    logic [1:0]  er;
    logic        eov;
    logic [31:0] eof;
    logic        eol;
  } vec_t;

  vec_t tbl[16];
  int vectors = 0;
  int miscompares = 0;

  // reference model state (2-input instance)
  int          m_lock, m_grant, m_prio, m_sel, m_req, m_acc;
  bit          m_ov, m_ol, m_free;
  logic [31:0] m_of;
  logic [1:0]  m_er;
  logic [31:0] rf0, rf1;
  logic [1:0]  rv, rl;
  logic        rordy, rrst;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive2(input logic [1:0] v, input logic [1:0] l,
                        input logic [31:0] f0, input logic [31:0] f1,
                        input logic ordy);
    b2.in_valid  = v;
    b2.in_last   = l;
    b2.in_flit   = {f1, f0};
    b2.out_ready = ordy;
  endtask

  task automatic chk_out2(input string nm, input logic ov,
                          input logic [31:0] of, input logic ol);
    chk({nm, " out_valid"}, 64'(b2.out_valid), 64'(ov));
    chk({nm, " out_flit"}, 64'(b2.out_flit), 64'(of));
    chk({nm, " out_last"}, 64'(b2.out_last), 64'(ol));
  endtask

  initial begin
    // {v, l, f0, f1, ordy, exp_ready, exp_ov, exp_oflit, exp_olast}
    tbl[0]  = '{2'b01, 2'b00, 32'hA0, 32'h0,  1'b1, 2'b01, 1'b1, 32'hA0, 1'b0};
    tbl[1]  = '{2'b11, 2'b00, 32'hA1, 32'hB0, 1'b1, 2'b01, 1'b1, 32'hA1, 1'b0};
    tbl[2]  = '{2'b11, 2'b01, 32'hA2, 32'hB0, 1'b1, 2'b01, 1'b1, 32'hA2, 1'b1};
    tbl[3]  = '{2'b11, 2'b10, 32'hC0, 32'hB0, 1'b1, 2'b10, 1'b1, 32'hB0, 1'b1};
    tbl[4]  = '{2'b11, 2'b11, 32'hC0, 32'hD0, 1'b1, 2'b01, 1'b1, 32'hC0, 1'b1};
    tbl[5]  = '{2'b11, 2'b11, 32'hC1, 32'hD0, 1'b1, 2'b10, 1'b1, 32'hD0, 1'b1};
    tbl[6]  = '{2'b01, 2'b00, 32'hE0, 32'h0,  1'b1, 2'b01, 1'b1, 32'hE0, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 32'hE1, 32'h9,  1'b0, 2'b00, 1'b1, 32'hE0, 1'b0};
    tbl[8]  = '{2'b11, 2'b00, 32'hE1, 32'h9,  1'b0, 2'b00, 1'b1, 32'hE0, 1'b0};
    tbl[9]  = '{2'b11, 2'b01, 32'hE1, 32'h9,  1'b1, 2'b01, 1'b1, 32'hE1, 1'b1};
    tbl[10] = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b0, 32'hE1, 1'b1};
    tbl[11] = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 2'b00, 1'b0, 32'hE1, 1'b1};
    tbl[12] = '{2'b10, 2'b00, 32'h0,  32'hF0, 1'b1, 2'b10, 1'b1, 32'hF0, 1'b0};
    tbl[13] = '{2'b01, 2'b00, 32'h55, 32'h0,  1'b1, 2'b10, 1'b0, 32'hF0, 1'b0};
    tbl[14] = '{2'b11, 2'b10, 32'h55, 32'hF1, 1'b1, 2'b10, 1'b1, 32'hF1, 1'b1};
    tbl[15] = '{2'b11, 2'b11, 32'hD6, 32'hD7, 1'b1, 2'b01, 1'b1, 32'hD6, 1'b1};

    rst = 1'b1;
    drive2(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    b4.in_valid = '0; b4.in_last = '0; b4.in_flit = '0; b4.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_out2("reset", 1'b0, 32'h0, 1'b0);
    chk("reset u4 out_valid", 64'(b4.out_valid), 64'(0));
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      drive2(tbl[i].v, tbl[i].l, tbl[i].f0, tbl[i].f1, tbl[i].ordy);
      #1;
      chk($sformatf("row%0d in_ready", i), 64'(b2.in_ready), 64'(tbl[i].er));
      @(posedge clk); #1;
      chk_out2($sformatf("row%0d", i), tbl[i].eov, tbl[i].eof, tbl[i].eol);
    end

    // reset in the middle of a worm from input 1
    @(negedge clk);
    drive2(2'b10, 2'b00, 32'h0, 32'h77, 1'b1);
    #1 chk("midworm hdr in_ready", 64'(b2.in_ready), 64'(2'b10));
    @(negedge clk);
    rst = 1'b1;
    drive2(2'b11, 2'b00, 32'h66, 32'h78, 1'b1);
    @(posedge clk); #1;
    chk_out2("midworm reset", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive2(2'b11, 2'b11, 32'h2A, 32'h2B, 1'b1);
    #1 chk("post reset in_ready", 64'(b2.in_ready), 64'(2'b01));
    @(posedge clk); #1;
    chk_out2("post reset", 1'b1, 32'h2A, 1'b1);

    // 4 inputs: move prio to 2, then inputs 0 and 3 compete
    @(negedge clk);
    drive2(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    b4.in_valid = 4'b0010; b4.in_last = 4'b0010; b4.out_ready = 1'b1;
    b4.in_flit = {32'h33, 32'h22, 32'h11, 32'h10};
    #1 chk("u4 single in_ready", 64'(b4.in_ready), 64'(4'b0010));
    @(negedge clk);
    b4.in_valid = 4'b1001; b4.in_last = 4'b1001;
    #1 chk("u4 prio2 in_ready", 64'(b4.in_ready), 64'(4'b1000));
    @(posedge clk); #1;
    chk("u4 prio2 out_flit", 64'(b4.out_flit), 64'(32'h33));
    @(negedge clk); #1;
    chk("u4 prio0 in_ready", 64'(b4.in_ready), 64'(4'b0001));
    @(posedge clk); #1;
    chk("u4 prio0 out_flit", 64'(b4.out_flit), 64'(32'h10));
    @(negedge clk);
    b4.in_valid = '0;

    // random run against a behavioural model of the 2-input instance
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rrst  = (c == 0) || ($urandom_range(0, 63) == 0);
      rv    = 2'($urandom);
      rl    = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom & $urandom);
      rf0   = $urandom;
      rf1   = $urandom;
      rordy = ($urandom_range(0, 3) != 0);
      rst   = rrst;
      drive2(rv, rl, rf0, rf1, rordy);
      #1;
      if (c > 0) begin
        m_free = !m_ov || rordy;
        m_req  = 0;
        m_sel  = 0;
        if (m_lock != 0) begin
          m_req = 1;
          m_sel = m_grant;
        end else begin
          for (int k = 0; k < 2; k++) begin
            if (m_req == 0 && rv[(m_prio + k) % 2]) begin
              m_req = 1;
              m_sel = (m_prio + k) % 2;
            end
          end
        end
        m_er  = (m_req != 0 && m_free) ? 2'(1 << m_sel) : 2'b00;
        m_acc = (m_req != 0 && m_free && rv[m_sel]) ? 1 : 0;
        chk($sformatf("rand%0d in_ready", c), 64'(b2.in_ready), 64'(m_er));
      end else begin
        m_acc = 0;
      end
      @(posedge clk); #1;
      if (rrst) begin
        m_lock = 0; m_grant = 0; m_prio = 0;
        m_ov = 0; m_ol = 0; m_of = '0;
      end else if (m_acc != 0) begin
        m_of = (m_sel == 1) ? rf1 : rf0;
        m_ol = rl[m_sel];
        m_ov = 1;
        if (m_lock == 0) begin
          m_prio = (m_sel + 1) % 2;
          if (!rl[m_sel]) begin
            m_lock  = 1;
            m_grant = m_sel;
          end
        end else if (rl[m_sel]) begin
          m_lock = 0;
        end
      end else if (rordy) begin
        m_ov = 0;
      end
      chk_out2($sformatf("rand%0d", c), m_ov, m_of, m_ol);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
